servio_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of the servio ROM write port. It parses framed records arriving on a valid/ready byte stream from the host link (UART/SPI front end). Each data byte becomes a single-cycle write strobe on the ROM's s1 write port. It reports frame completion, checksum failure and inter-byte timeout to the control logic.

---
 rtl/servio_pkg.sv | 33 +++
 rtl/servio_loader_timer.sv | 59 +++++
 rtl/servio_loader.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_servio_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servio_pkg.sv
// -----------------------------------------------------------------------------
// servio_pkg
// Shared definitions for the servio boot loader: the frame sync byte, the
// loader state encoding, the error codes reported on err_code, and the
// running-checksum helper.
// -----------------------------------------------------------------------------
package servio_pkg;

    // First byte of every frame; any other byte seen while idle is discarded.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Error codes presented on err_code alongside the err pulse.
    localparam logic [1:0] ERR_CKSUM   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Framing states, in the order the header fields arrive.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A_HI = 3'd1,
        ST_A_LO = 3'd2,
        ST_L_HI = 3'd3,
        ST_L_LO = 3'd4,
        ST_DATA = 3'd5,
        ST_CKS  = 3'd6
    } loader_state_e;

    // Modulo-256 accumulation used for the frame checksum.
    function automatic logic [7:0] cksum_add(input logic [7:0] sum,
                                             input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/servio_loader_timer.sv
// -----------------------------------------------------------------------------
// servio_loader_timer
// Inter-byte timeout counter. While enabled it counts clock cycles; clr_i
// restarts it from zero and takes priority over expiry, so a byte arriving
// on the last permitted cycle always wins. expire_o is asserted combinationally
// on the cycle whose edge would bring the count to LIMIT.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clr_i    in   restart the count (a byte was accepted)
//   en_i     in   count this cycle (a frame is in progress)
//   expire_o out  LIMIT idle cycles have elapsed at the coming edge
// -----------------------------------------------------------------------------
module servio_loader_timer #(
    parameter int unsigned LIMIT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    // Count spans 0 .. LIMIT-1; reaching LIMIT is the expiry event itself.
    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

    generate
        if (LIMIT < 1) begin : g_bad_limit
            $error("servio_loader_timer: LIMIT must be at least 1");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = en_i && !clr_i && (cnt_q == TERM);

    // Next count: restart on clear, when idle, or on expiry; otherwise step.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || (cnt_q == TERM)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servio_loader.sv
// -----------------------------------------------------------------------------
// servio_loader
// Byte-stream boot loader feeding the servio ROM s1 write port. Parses frames
//   A5, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN data bytes [, CKSUM]
// and turns every data byte into a single-cycle registered write strobe.
// The stream is never back-pressured: s_ready is high whenever out of reset.
//
// Build option: define SERVIO_LOADER_CKSUM_EN to expect a trailing CKSUM byte
// and check that the 8-bit sum of every byte after sync (CKSUM included) is 0.
// Without it the frame ends after the last data byte (or LEN_LO if LEN = 0)
// and no checksum logic is built.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   s_valid    in   input byte valid
//   s_ready    out  loader accepts byte
//   s_data     in   input byte
//   wb_m_adr   out  ROM write address (low $clog2(DATA_DEPTH) bits)
//   wb_m_cyc   out  one-cycle write strobe
//   wb_m_we    out  write enable, identical to wb_m_cyc
//   wb_m_dat   out  ROM write data
//   busy       out  frame in progress
//   done       out  one-cycle pulse, frame completed OK
//   err        out  one-cycle pulse, frame failed
//   err_code   out  01 checksum, 10 timeout; holds until the next err
// -----------------------------------------------------------------------------
module servio_loader
    import servio_pkg::*;
#(
    parameter int unsigned DATA_DEPTH     = 1024,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic [$clog2(DATA_DEPTH)-1:0] wb_m_adr,
    output logic                          wb_m_cyc,
    output logic                          wb_m_we,
    output logic [DATA_WIDTH-1:0]         wb_m_dat,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code
);

    localparam int unsigned   AW       = $clog2(DATA_DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DATA_DEPTH - 1);

`ifdef SERVIO_LOADER_CKSUM_EN
    localparam logic          CKSUM_EN = 1'b1;
    localparam loader_state_e ST_TAIL  = ST_CKS;
`else
    localparam logic          CKSUM_EN = 1'b0;
    localparam loader_state_e ST_TAIL  = ST_IDLE;
`endif

    generate
        if (DATA_WIDTH != 8) begin : g_bad_width
            $error("servio_loader: only DATA_WIDTH = 8 is supported");
        end
        if ((DATA_DEPTH < 2) || (DATA_DEPTH > 65536)) begin : g_bad_depth
            $error("servio_loader: DATA_DEPTH must lie in 2..65536");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    loader_state_e         state_q;
    loader_state_e         state_d;

    logic                  ready_q;
    logic [7:0]            addr_hi_q;
    logic [7:0]            addr_hi_d;
    logic [AW-1:0]         ptr_q;
    logic [AW-1:0]         ptr_d;
    logic [15:0]           len_q;
    logic [15:0]           len_d;

    logic                  wb_cyc_q;
    logic                  wb_cyc_d;
    logic [AW-1:0]         wb_adr_q;
    logic [AW-1:0]         wb_adr_d;
    logic [DATA_WIDTH-1:0] wb_dat_q;
    logic [DATA_WIDTH-1:0] wb_dat_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  done_d;
    logic                  err_q;
    logic                  err_d;
    logic [1:0]            err_code_q;
    logic [1:0]            err_code_d;

    logic                  accept_s;
    logic                  in_frame_s;
    logic                  expire_s;
    logic                  cksum_ok_s;
    logic [15:0]           addr_full_s;
    logic [15:0]           len_full_s;
    logic [AW-1:0]         ptr_inc_s;

    assign accept_s    = s_valid && ready_q;
    assign in_frame_s  = (state_q != ST_IDLE);
    assign addr_full_s = {addr_hi_q, s_data};
    assign len_full_s  = {len_q[15:8], s_data};
    // Explicit wrap keeps the pointer inside the ROM even for non-power-of-2 depths.
    assign ptr_inc_s   = (ptr_q == PTR_LAST) ? '0 : (ptr_q + 1'b1);

    // ------------------------------------------------------------------
    // Inter-byte timeout
    // ------------------------------------------------------------------
    servio_loader_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .clr_i    (accept_s),
        .en_i     (in_frame_s),
        .expire_o (expire_s)
    );

    // ------------------------------------------------------------------
    // Running checksum (only built when the CKSUM byte is part of the frame)
    // ------------------------------------------------------------------
`ifdef SERVIO_LOADER_CKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;

    // The frame is good when adding the CKSUM byte brings the sum to zero.
    assign cksum_ok_s = (cksum_add(sum_q, s_data) == 8'h00);

    // Sum restarts on any idle byte and accumulates every byte after sync.
    always_comb begin
        sum_d = sum_q;
        if (accept_s) begin
            if (state_q == ST_IDLE) begin
                sum_d = 8'h00;
            end else begin
                sum_d = cksum_add(sum_q, s_data);
            end
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`else
    assign cksum_ok_s = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a timeout abandons the frame from any state.
    always_comb begin
        state_d = state_q;
        if (expire_s) begin
            state_d = ST_IDLE;
        end else if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    // Non-sync bytes between frames are dropped silently.
                    if (s_data == SYNC_BYTE) begin
                        state_d = ST_A_HI;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_A_HI: state_d = ST_A_LO;
                ST_A_LO: state_d = ST_L_HI;
                ST_L_HI: state_d = ST_L_LO;
                ST_L_LO: begin
                    if (len_full_s == 16'd0) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // len_q counts the data bytes still to come.
                    if (len_q == 16'd1) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CKS:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output and datapath next values: header capture, write strobe, status.
    always_comb begin
        addr_hi_d  = addr_hi_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        wb_cyc_d   = 1'b0;
        wb_adr_d   = wb_adr_q;
        wb_dat_d   = wb_dat_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (expire_s) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    addr_hi_d = addr_hi_q;
                end
                ST_A_HI: begin
                    addr_hi_d = s_data;
                end
                ST_A_LO: begin
                    ptr_d = addr_full_s[AW-1:0];
                end
                ST_L_HI: begin
                    len_d = {s_data, 8'h00};
                end
                ST_L_LO: begin
                    len_d  = len_full_s;
                    // With no CKSUM byte an empty frame completes right here.
                    done_d = !CKSUM_EN && (len_full_s == 16'd0);
                end
                ST_DATA: begin
                    wb_cyc_d = 1'b1;
                    wb_adr_d = ptr_q;
                    wb_dat_d = s_data;
                    ptr_d    = ptr_inc_s;
                    len_d    = len_q - 16'd1;
                    done_d   = !CKSUM_EN && (len_q == 16'd1);
                end
                ST_CKS: begin
                    // Data has already been written; only the status reflects the result.
                    done_d = cksum_ok_s;
                    err_d  = !cksum_ok_s;
                    if (cksum_ok_s) begin
                        err_code_d = err_code_q;
                    end else begin
                        err_code_d = ERR_CKSUM;
                    end
                end
                default: begin
                    addr_hi_d = addr_hi_q;
                end
            endcase
        end else begin
            err_code_d = err_code_q;
        end
    end

    // Output, pointer and header registers; reset drops any pending strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q    <= 1'b0;
            addr_hi_q  <= 8'h00;
            ptr_q      <= '0;
            len_q      <= 16'd0;
            wb_cyc_q   <= 1'b0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            ready_q    <= 1'b1;
            addr_hi_q  <= addr_hi_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            wb_cyc_q   <= wb_cyc_d;
            wb_adr_q   <= wb_adr_d;
            wb_dat_q   <= wb_dat_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign s_ready  = ready_q;
    assign wb_m_adr = wb_adr_q;
    assign wb_m_cyc = wb_cyc_q;
    assign wb_m_we  = wb_cyc_q;
    assign wb_m_dat = wb_dat_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_servio_loader.sv
// -----------------------------------------------------------------------------
// tb_servio_loader
// Randomised and directed frames for servio_loader. Each frame's expected ROM
// writes (base + i modulo depth) and its expected completion status are queued
// when the frame is sent; a monitor on the falling edge pops and compares them
// whenever the DUT strobes a write or pulses done/err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_servio_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int TO    = 16;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [7:0]    dat;
    } wr_t;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic [AW-1:0] wb_m_adr;
    logic          wb_m_cyc;
    logic          wb_m_we;
    logic [7:0]    wb_m_dat;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    wr_t        wq[$];
    ev_t        eq[$];
    logic [7:0] payload[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    servio_loader #(
        .DATA_DEPTH     (DEPTH),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .wb_m_adr (wb_m_adr),
        .wb_m_cyc (wb_m_cyc),
        .wb_m_we  (wb_m_we),
        .wb_m_dat (wb_m_dat),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int gap(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // Called at posedge+1; leaves at posedge+1 after the byte's accepting edge.
    // exp = {wb_m_cyc, done, err} expected one cycle after acceptance.
    task automatic send_byte(input logic [7:0] b, input int g, input logic [2:0] exp);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("strobe_timing", {29'd0, wb_m_cyc, done, err}, {29'd0, exp});
    endtask

    // Sends a frame carrying 'payload'. stop_after >= 0 abandons it after that
    // many data bytes (no completion status is expected then).
    task automatic send_frame(input logic [15:0] addr, input bit bad,
                              input int gmin, input int gmax, input int stop_after);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [15:0] len;
        logic [2:0]  exp;
        int          base;
        wr_t         w;
        ev_t         ev;
        len  = 16'(payload.size());
        base = int'(addr) % DEPTH;
        sum  = 8'h00;
        chk("ready", {31'd0, s_ready}, 32'd1);
        if (stop_after < 0) begin
`ifdef SERVIO_LOADER_CKSUM_EN
            ev.is_err = bad;
            ev.code   = bad ? 2'b01 : 2'b00;
`else
            ev.is_err = 1'b0;
            ev.code   = 2'b00;
`endif
            eq.push_back(ev);
        end
        send_byte(8'hA5, gap(gmin, gmax), 3'b000);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        send_byte(addr[15:8], gap(gmin, gmax), 3'b000);
        send_byte(addr[7:0],  gap(gmin, gmax), 3'b000);
        send_byte(len[15:8],  gap(gmin, gmax), 3'b000);
        sum = addr[15:8] + addr[7:0] + len[15:8] + len[7:0];
`ifdef SERVIO_LOADER_CKSUM_EN
        exp = 3'b000;
`else
        exp = (len == 16'd0) ? 3'b010 : 3'b000;
`endif
        send_byte(len[7:0], gap(gmin, gmax), exp);
        for (int i = 0; i < payload.size(); i++) begin
            if (i == stop_after) return;
            b     = payload[i];
            sum   = sum + b;
            w.adr = AW'((base + i) % DEPTH);
            w.dat = b;
            wq.push_back(w);
`ifdef SERVIO_LOADER_CKSUM_EN
            exp = 3'b100;
`else
            exp = (i == payload.size() - 1) ? 3'b110 : 3'b100;
`endif
            send_byte(b, gap(gmin, gmax), exp);
        end
`ifdef SERVIO_LOADER_CKSUM_EN
        b = 8'h00 - sum;
        if (bad) b = b + 8'($urandom_range(255, 1));
        send_byte(b, gap(gmin, gmax), bad ? 3'b001 : 3'b010);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: compares every write strobe and status pulse.
    initial begin
        wr_t w;
        ev_t e;
        forever begin
            @(negedge clk);
            if (wb_m_cyc) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_bad++;
                    $display("FAIL write_unexpected: got adr=%0h dat=%0h expected no write", wb_m_adr, wb_m_dat);
                end else begin
                    w = wq.pop_front();
                    if ({wb_m_we, wb_m_adr, wb_m_dat} !== {1'b1, w.adr, w.dat}) begin
                        n_bad++;
                        $display("FAIL write: got we=%0b adr=%0h dat=%0h expected we=1 adr=%0h dat=%0h",
                                 wb_m_we, wb_m_adr, wb_m_dat, w.adr, w.dat);
                    end
                end
            end
            if (done || err) begin
                n_cmp++;
                if (eq.size() == 0) begin
                    n_bad++;
                    $display("FAIL status_unexpected: got done=%0b err=%0b code=%0b expected none", done, err, err_code);
                end else begin
                    e = eq.pop_front();
                    if ({err, (err ? err_code : 2'b00), done} !== {e.is_err, e.code, ~e.is_err}) begin
                        n_bad++;
                        $display("FAIL status: got done=%0b err=%0b code=%0b expected err=%0b code=%0b",
                                 done, err, err_code, e.is_err, e.code);
                    end
                end
            end
        end
    end

    initial begin
        ev_t        ev;
        logic [7:0] b;
        int         nj;
        int         ln;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {19'd0, s_ready, wb_m_cyc, wb_m_we, busy, done, err, err_code, wb_m_dat},
            32'd0);
        chk("rst_adr", {22'd0, wb_m_adr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, s_ready}, 32'd1);

        // 1/2: basic frame, then the same frame with a wrong checksum
        payload = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h0010, 1'b0, 0, 0, -1);
        send_frame(16'h0010, 1'b1, 0, 0, -1);

        // 3: pointer wraps from DEPTH-1 to 0
        payload = '{8'hAA, 8'hBB};
        send_frame(16'h03FF, 1'b0, 0, 1, -1);

        // 4: timeout after two header bytes, then a good frame
        ev.is_err = 1'b1;
        ev.code   = 2'b10;
        eq.push_back(ev);
        send_byte(8'hA5, 0, 3'b000);
        send_byte(8'h00, 0, 3'b000);
        send_byte(8'h00, 0, 3'b000);
        repeat (TO + 4) @(posedge clk);
        #1;
        chk("busy_after_timeout", {31'd0, busy}, 32'd0);
        chk("err_code_hold", {30'd0, err_code}, 32'd2);
        payload = '{8'h5A, 8'hC3, 8'h01, 8'hFE};
        send_frame(16'h1234, 1'b0, 0, 2, -1);

        // longest gap that must not time out
        payload = '{8'h77, 8'h88};
        send_frame(16'h0200, 1'b0, TO - 1, TO - 1, -1);

        // 5: junk before a frame, then an empty frame
        send_byte(8'h00, 0, 3'b000);
        send_byte(8'hFF, 1, 3'b000);
        send_byte(8'h5A, 0, 3'b000);
        payload = '{8'h10, 8'h20};
        send_frame(16'h0100, 1'b0, 0, 0, -1);
        payload.delete();
        send_frame(16'h0042, 1'b0, 0, 1, -1);

        // sync value inside the payload is ordinary data
        payload = '{8'hA5, 8'hA5, 8'h00};
        send_frame(16'h0300, 1'b0, 0, 1, -1);

        // 6: reset during DATA after 1 of 4 bytes
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(16'h0080, 1'b0, 0, 0, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {25'd0, s_ready, wb_m_cyc, busy, done, err, err_code}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        payload = '{8'h9A, 8'hBC};
        send_frame(16'h0081, 1'b0, 0, 1, -1);

        // LEN > DEPTH overwrites earlier locations
        payload.delete();
        for (int i = 0; i < DEPTH + 76; i++) payload.push_back(8'($urandom_range(255, 0)));
        send_frame(16'h7FF0, 1'b0, 0, 0, -1);

        // randomised traffic
        for (int f = 0; f < 40; f++) begin
            nj = int'($urandom_range(2, 0));
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom_range(255, 0));
                if (b == 8'hA5) b = 8'h3C;
                send_byte(b, gap(0, 2), 3'b000);
            end
            payload.delete();
            ln = int'($urandom_range(8, 0));
            for (int i = 0; i < ln; i++) payload.push_back(8'($urandom_range(255, 0)));
            send_frame(16'($urandom), ($urandom_range(3, 0) == 0), 0, 3, -1);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("writes_drained", wq.size(), 32'd0);
        chk("status_drained", eq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
